sys_bus_arbiter: RTL

- Parametrised N-master arbiter for the CPU memory-controller bus. It replaces the fixed two-way rp2a03/hci select with registered request/grant arbitration.
- Supports fixed-priority or round-robin mode, a bounded hold time with preemption, and per-master bus lock.
- Sits between bus masters (CPU core, debug HCI, DMA engines) and the shared cpumc address/data/r_nw bus, which is decoded by cart, wram and ppu.

---
 rtl/sys_bus_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: N-master request/grant arbiter for the shared cpumc bus.
// Fixed-priority or round-robin selection, bounded hold with preemption,
// per-master lock, and a combinational bus mux driven by the registered owner.
//
// Ports:
//   clk_in        system clock
//   nrst_in       asynchronous active-low reset
//   req_in        bus request per master
//   lock_in       per-master lock; a locked owner is never preempted
//   a_in          master addresses, master i at [i*AW +: AW]
//   r_nw_in       master read/not-write
//   d_in          master write data, master i at [i*DW +: DW]
//   bus_d_in      OR-combined slave read data
//   gnt_out       one-hot grant, doubles as per-master rdy
//   bus_a_out     shared bus address (0 when idle)
//   bus_r_nw_out  shared bus read/not-write (1 when idle)
//   bus_d_out     shared bus write data (0 when idle)
//   d_out         read data broadcast to all masters
//   active_out    a grant is held
//   owner_out     index of current owner (0 when idle)
module sys_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int RR_MODE     = 0,
    parameter int MAX_HOLD    = 16,
    parameter int OWNER_W     = 3
) (
    input  logic                      clk_in,
    input  logic                      nrst_in,
    input  logic [NUM_MASTERS-1:0]    req_in,
    input  logic [NUM_MASTERS-1:0]    lock_in,
    input  logic [NUM_MASTERS*AW-1:0] a_in,
    input  logic [NUM_MASTERS-1:0]    r_nw_in,
    input  logic [NUM_MASTERS*DW-1:0] d_in,
    input  logic [DW-1:0]             bus_d_in,
    output logic [NUM_MASTERS-1:0]    gnt_out,
    output logic [AW-1:0]             bus_a_out,
    output logic                      bus_r_nw_out,
    output logic [DW-1:0]             bus_d_out,
    output logic [DW-1:0]             d_out,
    output logic                      active_out,
    output logic [OWNER_W-1:0]        owner_out
);

    localparam int HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]      HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [OWNER_W:0]   NM       = (OWNER_W + 1)'(NUM_MASTERS);
    localparam logic [OWNER_W-1:0] LAST     = OWNER_W'(NUM_MASTERS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OWNED = 1'b1
    } state_t;

    state_t               r_state;
    logic [OWNER_W-1:0]   r_owner;
    logic [HW-1:0]        r_hold;
    logic [OWNER_W-1:0]   r_ptr;

    state_t               w_nxt_state;
    logic [OWNER_W-1:0]   w_nxt_owner;
    logic [HW-1:0]        w_nxt_hold;
    logic [OWNER_W-1:0]   w_nxt_ptr;

    logic [NUM_MASTERS-1:0] w_gnt;
    logic [NUM_MASTERS-1:0] w_others;
    logic [NUM_MASTERS-1:0] w_cand;
    logic [OWNER_W-1:0]     w_pick;
    logic                   w_grant;
    logic                   w_own_req;
    logic                   w_own_lock;
    logic                   w_preempt;

    // First set bit of req searching upward from base, with wrap.
    // Rotating right by base puts the search start at bit 0.
    function automatic logic [OWNER_W-1:0] f_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [OWNER_W-1:0]     base
    );
        logic [NUM_MASTERS-1:0] rot;
        logic [OWNER_W:0]       sum;
        logic [OWNER_W-1:0]     off;
        rot = NUM_MASTERS'({req, req} >> base);
        off = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = OWNER_W'(i);
            end
        end
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NM) begin
            sum = sum - NM;
        end
        return sum[OWNER_W-1:0];
    endfunction

    assign w_own_req  = |(req_in & w_gnt);
    assign w_own_lock = |(lock_in & w_gnt);
    assign w_others   = req_in & ~w_gnt;
    assign w_preempt  = (MAX_HOLD != 0) && (r_hold == HOLD_MAX)
                        && !w_own_lock && (|w_others);

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_hold  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_owner <= w_nxt_owner;
            r_hold  <= w_nxt_hold;
            r_ptr   <= w_nxt_ptr;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_owner = r_owner;
        w_nxt_hold  = r_hold;
        w_nxt_ptr   = r_ptr;
        w_cand      = '0;
        w_grant     = 1'b0;
        w_pick      = '0;
        unique case (r_state)
            S_IDLE: begin
                if (|req_in) begin
                    w_grant = 1'b1;
                    w_cand  = req_in;
                end
            end
            S_OWNED: begin
                if (!w_own_req) begin
                    // Release hands straight to a pending master, no bubble.
                    if (|req_in) begin
                        w_grant = 1'b1;
                        w_cand  = req_in;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_owner = '0;
                        w_nxt_hold  = '0;
                    end
                end else if (w_preempt) begin
                    w_grant = 1'b1;
                    w_cand  = w_others;
                end else if ((|w_others) && (r_hold != HOLD_MAX)) begin
                    w_nxt_hold = r_hold + 1'b1;
                end
            end
            default: ;
        endcase
        if (w_grant) begin
            w_pick      = f_pick(w_cand, (RR_MODE != 0) ? r_ptr : '0);
            w_nxt_state = S_OWNED;
            w_nxt_owner = w_pick;
            w_nxt_hold  = '0;
            w_nxt_ptr   = (w_pick == LAST) ? '0 : w_pick + 1'b1;
        end
    end

    always_comb begin
        w_gnt        = '0;
        bus_a_out    = '0;
        bus_r_nw_out = 1'b1;
        bus_d_out    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_state == S_OWNED && r_owner == OWNER_W'(i)) begin
                w_gnt[i]     = 1'b1;
                bus_a_out    = a_in[i*AW +: AW];
                bus_r_nw_out = r_nw_in[i];
                bus_d_out    = d_in[i*DW +: DW];
            end
        end
    end

    assign gnt_out    = w_gnt;
    assign active_out = (r_state == S_OWNED);
    assign owner_out  = r_owner;
    assign d_out      = bus_d_in;

endmodule
